seq_controller: RTL and testbench

SEQ_CONTROLLER -- requirements
Module: seq_controller

---
 rtl/seq_controller.sv | 259 +++++++++++++++++++++++++
 tb/tb_seq_controller.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_controller.sv
// rtl/seq_controller.sv - multi-cycle fetch/decode/execute/memory/writeback sequencer
//
// Purpose: steps one instruction at a time through FETCH, DECODE, EXECUTE,
// MEMORY, WRITEBACK and PCUPD, raising one stage strobe per cycle. Faults
// detected at fetch or during the data-memory access stop the machine in
// HALTED with a status code, keeping the address of the faulting instruction.
//
// Ports:
//   i_clock, i_reset           clock, synchronous active-high reset
//   i_start                    leave IDLE / restart from HALTED
//   i_icode                    fetched instruction code
//   i_instruction_valid        fetch decoded a legal instruction
//   i_imem_error               fetch address out of range
//   i_memory_block_error       data memory address error (MEMORY only)
//   i_mem_ready                data memory completes the current access
//   i_new_pc                   next PC, loaded in PCUPD
//   o_pc_counter               committed PC driving fetch
//   o_fetch_en..o_writeback_en one-cycle stage strobes
//   o_mem_req                  data memory access request
//   o_stat                     1=AOK 2=HLT 3=ADR 4=INS
//   o_running                  high outside IDLE and HALTED
//   o_cycle_count              running cycles, saturating
//   o_instr_count              retired instructions, saturating

module seq_controller #(
    parameter logic [63:0] RESET_PC    = 64'd0,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [3:0]  i_icode,
    input  logic        i_instruction_valid,
    input  logic        i_imem_error,
    input  logic        i_memory_block_error,
    input  logic        i_mem_ready,
    input  logic [63:0] i_new_pc,
    output logic [63:0] o_pc_counter,
    output logic        o_fetch_en,
    output logic        o_decode_en,
    output logic        o_execute_en,
    output logic        o_memory_en,
    output logic        o_writeback_en,
    output logic        o_mem_req,
    output logic [2:0]  o_stat,
    output logic        o_running,
    output logic [31:0] o_cycle_count,
    output logic [31:0] o_instr_count
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_PCUPD     = 3'd6,
        S_HALTED    = 3'd7
    } state_t;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    // r_wait counts completed mem_req cycles; it only has to reach MEM_TIMEOUT-1.
    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t              r_state;
    logic [63:0]         r_pc;
    logic [2:0]          r_stat;
    logic [31:0]         r_cycle_count;
    logic [31:0]         r_instr_count;
    logic [3:0]          r_icode;
    logic [WAIT_W-1:0]   r_wait;

    state_t              w_next_state;
    logic                w_fault;
    logic [2:0]          w_fault_stat;
    logic                w_restart;
    logic                w_pc_load;
    logic                w_latch_icode;
    logic                w_wait_clr;
    logic                w_wait_inc;
    logic                w_is_mem_op;

    // Instructions that access data memory: the icode is captured at fetch so
    // the decision in MEMORY does not depend on the fetch bus staying stable.
    always_comb begin
        w_is_mem_op = 1'b0;
        case (r_icode)
            4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: w_is_mem_op = 1'b1;
            default:                            w_is_mem_op = 1'b0;
        endcase
    end

    always_comb begin
        w_next_state   = r_state;
        w_fault        = 1'b0;
        w_fault_stat   = STAT_AOK;
        w_restart      = 1'b0;
        w_pc_load      = 1'b0;
        w_latch_icode  = 1'b0;
        w_wait_clr     = 1'b0;
        w_wait_inc     = 1'b0;
        o_fetch_en     = 1'b0;
        o_decode_en    = 1'b0;
        o_execute_en   = 1'b0;
        o_memory_en    = 1'b0;
        o_writeback_en = 1'b0;
        o_mem_req      = 1'b0;
        o_running      = 1'b1;

        case (r_state)
            S_IDLE: begin
                o_running = 1'b0;
                if (i_start) begin
                    w_next_state = S_FETCH;
                end
            end

            S_FETCH: begin
                o_fetch_en    = 1'b1;
                w_latch_icode = 1'b1;
                // Fault priority: address, then illegal code, then halt.
                if (i_imem_error) begin
                    w_fault      = 1'b1;
                    w_fault_stat = STAT_ADR;
                end else if (!i_instruction_valid) begin
                    w_fault      = 1'b1;
                    w_fault_stat = STAT_INS;
                end else if (i_icode == 4'h0) begin
                    w_fault      = 1'b1;
                    w_fault_stat = STAT_HLT;
                end
                w_next_state = w_fault ? S_HALTED : S_DECODE;
            end

            S_DECODE: begin
                o_decode_en  = 1'b1;
                w_next_state = S_EXECUTE;
            end

            S_EXECUTE: begin
                o_execute_en = 1'b1;
                w_wait_clr   = 1'b1;
                w_next_state = S_MEMORY;
            end

            S_MEMORY: begin
                // Strobe only on the entry cycle; r_wait is still zero there.
                o_memory_en = (r_wait == '0);
                o_mem_req   = w_is_mem_op;
                if (i_memory_block_error) begin
                    w_fault      = 1'b1;
                    w_fault_stat = STAT_ADR;
                    w_next_state = S_HALTED;
                end else if (!w_is_mem_op || i_mem_ready) begin
                    w_next_state = S_WRITEBACK;
                end else if (r_wait == WAIT_LAST) begin
                    // This was the last permitted mem_req cycle without ready.
                    w_fault      = 1'b1;
                    w_fault_stat = STAT_ADR;
                    w_next_state = S_HALTED;
                end else begin
                    w_wait_inc = 1'b1;
                end
            end

            S_WRITEBACK: begin
                o_writeback_en = 1'b1;
                w_next_state   = S_PCUPD;
            end

            S_PCUPD: begin
                w_pc_load    = 1'b1;
                w_next_state = S_FETCH;
            end

            S_HALTED: begin
                o_running = 1'b0;
                if (i_start) begin
                    w_restart    = 1'b1;
                    w_next_state = S_FETCH;
                end
            end

            default: begin
                o_running    = 1'b0;
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Architectural state: PC and status only move on commit, fault or restart.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_pc   <= RESET_PC;
            r_stat <= STAT_AOK;
        end else if (w_restart) begin
            r_pc   <= RESET_PC;
            r_stat <= STAT_AOK;
        end else begin
            if (w_pc_load) begin
                r_pc <= i_new_pc;
            end
            if (w_fault) begin
                r_stat <= w_fault_stat;
            end
        end
    end

    // Performance counters hold at all-ones instead of wrapping.
    always_ff @(posedge i_clock) begin
        if (i_reset || w_restart) begin
            r_cycle_count <= 32'd0;
            r_instr_count <= 32'd0;
        end else begin
            if (o_running && (r_cycle_count != 32'hFFFF_FFFF)) begin
                r_cycle_count <= r_cycle_count + 32'd1;
            end
            if (w_pc_load && (r_instr_count != 32'hFFFF_FFFF)) begin
                r_instr_count <= r_instr_count + 32'd1;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_icode <= 4'h0;
            r_wait  <= '0;
        end else begin
            if (w_latch_icode) begin
                r_icode <= i_icode;
            end
            if (w_wait_clr) begin
                r_wait <= '0;
            end else if (w_wait_inc) begin
                r_wait <= r_wait + WAIT_W'(1);
            end
        end
    end

    assign o_pc_counter  = r_pc;
    assign o_stat        = r_stat;
    assign o_cycle_count = r_cycle_count;
    assign o_instr_count = r_instr_count;

endmodule

// File: tb/tb_seq_controller.sv
// tb/tb_seq_controller.sv - scoreboard bench for seq_controller

module tb_seq_controller;

    localparam int TMO = 15;
    localparam int N   = 60;

    typedef struct {
        bit          is_halt;
        logic [63:0] pc;
        logic [2:0]  stat;
        logic [31:0] ic;
        logic [31:0] cc;
        int          mreq;
        int          wb;
    } obs_t;

    typedef struct {
        logic [3:0]  icode;
        bit          valid;
        bit          ierr;
        int          rdy;
        int          err;
        logic [63:0] npc;
    } instr_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  icode;
    logic        valid;
    logic        ierr;
    logic        blk;
    logic        mem_ready;
    logic [63:0] new_pc;
    logic [63:0] pc_counter;
    logic        fetch_en, decode_en, execute_en, memory_en, writeback_en;
    logic        mem_req;
    logic [2:0]  stat;
    logic        running;
    logic [31:0] cycle_count, instr_count;

    seq_controller #(.RESET_PC(64'd0), .MEM_TIMEOUT(TMO)) dut (
        .i_clock              (clk),
        .i_reset              (reset),
        .i_start              (start),
        .i_icode              (icode),
        .i_instruction_valid  (valid),
        .i_imem_error         (ierr),
        .i_memory_block_error (blk),
        .i_mem_ready          (mem_ready),
        .i_new_pc             (new_pc),
        .o_pc_counter         (pc_counter),
        .o_fetch_en           (fetch_en),
        .o_decode_en          (decode_en),
        .o_execute_en         (execute_en),
        .o_memory_en          (memory_en),
        .o_writeback_en       (writeback_en),
        .o_mem_req            (mem_req),
        .o_stat               (stat),
        .o_running            (running),
        .o_cycle_count        (cycle_count),
        .o_instr_count        (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int     n_cmp = 0;
    int     n_fail = 0;
    obs_t   exp_q[$];
    instr_t prog[N];
    instr_t cur;
    int     next_idx = 0;
    int     mcnt = 0;
    int     gap = 2;
    bit     done = 0;
    bit     mon_en = 0;
    int     ev_num = 0;

    logic [63:0] m_pc;
    logic [31:0] m_ic, m_cc;
    int          m_last_mreq, m_last_wb;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit is_mem(input logic [3:0] c);
        return c inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
    endfunction

    // Reference model: outcome of one instruction from the architectural rules.
    task automatic model_issue(input instr_t in);
        obs_t       e;
        bit         halt;
        bit         tmo;
        int         tend;
        int         len;
        int         mr;
        logic [2:0] st;
        e.is_halt = 0; e.pc = m_pc; e.stat = 3'd1; e.ic = m_ic; e.cc = m_cc;
        e.mreq = m_last_mreq; e.wb = m_last_wb;
        exp_q.push_back(e);
        halt = 1; mr = 0; st = 3'd1; len = 1;
        if (in.ierr) st = 3'd3;
        else if (!in.valid) st = 3'd4;
        else if (in.icode == 4'h0) st = 3'd2;
        else begin
            if (is_mem(in.icode)) begin
                tmo  = !(in.rdy >= 1 && in.rdy <= TMO);
                tend = tmo ? TMO : in.rdy;
            end else begin
                tmo  = 0;
                tend = 1;
            end
            if (in.err >= 1 && in.err <= tend) begin
                st = 3'd3; len = 3 + in.err; mr = is_mem(in.icode) ? in.err : 0;
            end else if (tmo) begin
                st = 3'd3; len = 3 + TMO; mr = TMO;
            end else begin
                halt = 0; len = 5 + tend; mr = is_mem(in.icode) ? tend : 0;
            end
        end
        if (halt) begin
            e.is_halt = 1; e.pc = m_pc; e.stat = st; e.ic = m_ic; e.cc = m_cc + 32'(len);
            e.mreq = mr; e.wb = 0;
            exp_q.push_back(e);
            m_pc = 64'd0; m_ic = 0; m_cc = 0; m_last_mreq = 0; m_last_wb = 0;
        end else begin
            m_cc = m_cc + 32'(len); m_ic = m_ic + 1; m_pc = in.npc;
            m_last_mreq = mr; m_last_wb = 1;
        end
    endtask

    // Environment: supplies fetch data, memory responses and start pulses.
    task automatic drive_step();
        mem_ready = 1'b0;
        blk       = 1'b0;
        if (running) begin
            start = 1'($urandom_range(0, 1));
            if (fetch_en) begin
                cur    = prog[next_idx];
                next_idx++;
                icode  = cur.icode;
                valid  = cur.valid;
                ierr   = cur.ierr;
                new_pc = cur.npc;
                mcnt   = 0;
                model_issue(cur);
            end
            if (memory_en || mem_req) begin
                mcnt++;
                if (is_mem(cur.icode) && mcnt == cur.rdy) mem_ready = 1'b1;
                if (mcnt == cur.err) blk = 1'b1;
            end
        end else if (next_idx >= N) begin
            start = 1'b0;
            done  = 1;
        end else if (gap > 0) begin
            start = 1'b0;
            gap--;
        end else begin
            start = 1'b1;
            gap   = $urandom_range(0, 3);
        end
    endtask

    task automatic compare_obs(input obs_t a);
        obs_t  e;
        string p;
        p = $sformatf("sb%0d", ev_num);
        ev_num++;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_unexpected: got event halt=%0d pc=0x%0h, expected none", p, a.is_halt, a.pc);
            return;
        end
        e = exp_q.pop_front();
        check({p, "_kind"}, 64'(a.is_halt), 64'(e.is_halt));
        check({p, "_pc"},   a.pc, e.pc);
        check({p, "_stat"}, 64'(a.stat), 64'(e.stat));
        check({p, "_instr_count"}, 64'(a.ic), 64'(e.ic));
        check({p, "_cycle_count"}, 64'(a.cc), 64'(e.cc));
        check({p, "_mem_req_cycles"}, 64'(a.mreq), 64'(e.mreq));
        check({p, "_writeback_cycles"}, 64'(a.wb), 64'(e.wb));
    endtask

    // Monitor: samples outputs just after the falling edge.
    initial begin
        bit   prev_run;
        int   mreq_cnt;
        int   wb_cnt;
        int   ns;
        obs_t o;
        prev_run = 0; mreq_cnt = 0; wb_cnt = 0;
        forever begin
            @(negedge clk);
            #1;
            if (mon_en) begin
                ns = int'(fetch_en) + int'(decode_en) + int'(execute_en)
                   + int'(memory_en) + int'(writeback_en);
                check("strobe_at_most_one", 64'(ns <= 1), 64'd1);
                if (!running) check("strobes_low_when_stopped", 64'(ns + int'(mem_req)), 64'd0);
                if (mem_req) mreq_cnt++;
                if (writeback_en) wb_cnt++;
                if (fetch_en || (prev_run && !running)) begin
                    o.is_halt = !fetch_en; o.pc = pc_counter; o.stat = stat;
                    o.ic = instr_count; o.cc = cycle_count; o.mreq = mreq_cnt; o.wb = wb_cnt;
                    compare_obs(o);
                    mreq_cnt = 0;
                    wb_cnt   = 0;
                end
            end
            prev_run = running;
        end
    end

    task automatic check_idle(input string p);
        check({p, "_running"},   64'(running), 64'd0);
        check({p, "_mem_req"},   64'(mem_req), 64'd0);
        check({p, "_strobes"},   64'({fetch_en, decode_en, execute_en, memory_en, writeback_en}), 64'd0);
        check({p, "_stat"},      64'(stat), 64'd1);
        check({p, "_pc"},        pc_counter, 64'd0);
        check({p, "_cycles"},    64'(cycle_count), 64'd0);
        check({p, "_instrs"},    64'(instr_count), 64'd0);
    endtask

    initial begin
        int k;
        reset = 1'b1; start = 1'b1; icode = 4'h0; valid = 1'b0; ierr = 1'b1;
        blk = 1'b1; mem_ready = 1'b0; new_pc = 64'd0;
        m_pc = 64'd0; m_ic = 0; m_cc = 0; m_last_mreq = 0; m_last_wb = 0;

        for (int i = 0; i < N; i++) begin
            prog[i].icode = ($urandom_range(0, 9) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            prog[i].ierr  = ($urandom_range(0, 11) == 0);
            prog[i].valid = ($urandom_range(0, 11) != 0);
            prog[i].rdy   = $urandom_range(0, 18);
            prog[i].err   = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 16) : 0;
            prog[i].npc   = {$urandom, $urandom};
        end
        prog[N-1].icode = 4'h0; prog[N-1].valid = 1; prog[N-1].ierr = 0;

        // Reset dominates start and fault inputs.
        repeat (3) @(negedge clk);
        check_idle("reset");
        reset = 1'b0; start = 1'b0; ierr = 1'b0; blk = 1'b0; valid = 1'b1;
        @(negedge clk);
        check("idle_without_start", 64'(running), 64'd0);

        mon_en = 1;
        for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
            @(negedge clk);
            drive_step();
        end
        check("random_phase_done", 64'(done), 64'd1);
        repeat (2) @(negedge clk);
        mon_en = 0;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        // Reset in the middle of a memory wait, from HALTED.
        icode = 4'h5; valid = 1'b1; ierr = 1'b0; mem_ready = 1'b0; blk = 1'b0;
        new_pc = 64'h40; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("d_restart_fetch", 64'(fetch_en), 64'd1);
        k = 0;
        while (!mem_req && k < 20) begin @(negedge clk); k++; end
        repeat (2) @(negedge clk);
        check("d_mem_wait", 64'(mem_req), 64'd1);
        reset = 1'b1; start = 1'b1; blk = 1'b1;
        @(negedge clk);
        check_idle("d_reset_in_mem");
        reset = 1'b0; blk = 1'b0;

        // One plain instruction, then a halt at the new PC.
        icode = 4'h6; new_pc = 64'h14;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!writeback_en && k < 20) begin @(negedge clk); k++; end
        check("d_writeback_seen", 64'(writeback_en), 64'd1);
        icode = 4'h0;
        k = 0;
        while (running && k < 20) begin @(negedge clk); k++; end
        check("d_halt_stat", 64'(stat), 64'd2);
        check("d_halt_pc", pc_counter, 64'h14);
        check("d_halt_instrs", 64'(instr_count), 64'd1);
        check("d_halt_cycles", 64'(cycle_count), 64'd7);
        repeat (3) @(negedge clk);
        check("d_halted_quiet", 64'({running, fetch_en, decode_en, execute_en, memory_en, writeback_en, mem_req}), 64'd0);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("d_restart_fetch2", 64'(fetch_en), 64'd1);
        check("d_restart_pc", pc_counter, 64'd0);
        check("d_restart_stat", 64'(stat), 64'd1);
        check("d_restart_cycles", 64'(cycle_count), 64'd0);
        check("d_restart_instrs", 64'(instr_count), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
